lsu_mem_ctrl: RTL and testbench

Initiator side of the core's simulation memory port. Accepts one load or store at a time from the pipeline over a valid/ready handshake, drives men/mwen/raddr/waddr/wdata/wmask toward the DPI-backed memory model for exactly one cycle per access, and returns a sign/zero-extended load result or store completion. Sits between the MEM stage and the memory model.

---
 rtl/lsu_pkg.sv | 40 ++++
 rtl/lsu_load_align.sv | 14 +
 rtl/lsu_mem_ctrl.sv | 116 +++++++++++
 tb/tb_lsu_mem_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store memory port.
// Also used by the later cache path.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

  // Lanes that fall past the 8-byte boundary are shifted out and dropped.
  function automatic logic [7:0] size_mask(input logic [1:0] size, input logic [2:0] offset);
    logic [7:0] lanes;
    case (size)
      SZ_B:    lanes = 8'h01;
      SZ_H:    lanes = 8'h03;
      SZ_W:    lanes = 8'h0F;
      default: lanes = 8'hFF;
    endcase
    return lanes << offset;
  endfunction

  function automatic logic [63:0] load_extend(input logic [63:0] word, input logic [2:0] offset,
                                              input logic [1:0] size, input logic is_unsigned);
    logic [63:0] shifted;
    shifted = word >> {offset, 3'b000};
    case (size)
      SZ_B:    return is_unsigned ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      SZ_H:    return is_unsigned ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      SZ_W:    return is_unsigned ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: return shifted;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational shift, truncate and sign/zero-extend of a fetched 8-byte word.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [63:0] word,
  input  logic [2:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [63:0] data
);

  assign data = load_extend(word, offset, size, is_unsigned);

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Single-outstanding load/store initiator toward the simulation memory model.
// Exactly one men pulse per accepted request; misaligned requests may bypass memory.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wen,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            men,
  output logic            mwen,
  output logic [XLEN-1:0] raddr,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] waddr,
  output logic [XLEN-1:0] wdata,
  output logic [7:0]      wmask
);

  state_t            state, state_next;
  logic              wen_q, uns_q, err_q;
  logic [XLEN-1:0]   addr_q, wdata_q, rdata_q;
  logic [1:0]        size_q;
  logic [XLEN-1:0]   load_data, line_addr;
  logic [2:0]        low_mask;
  logic              misaligned_req;

  assign low_mask       = 3'((4'd1 << req_size) - 4'd1);
  assign misaligned_req = ALIGN_CHECK && ((req_addr[2:0] & low_mask) != 3'd0);
  assign line_addr      = {addr_q[XLEN-1:3], 3'b000};

  lsu_load_align u_load_align (
    .word        (rdata),
    .offset      (addr_q[2:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .data        (load_data)
  );

  always_comb begin
    // NOTE: every output and next-state gets a default first so no path infers a latch.
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    men        = 1'b0;
    mwen       = 1'b0;
    raddr      = '0;
    waddr      = '0;
    wdata      = '0;
    wmask      = '0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = misaligned_req ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        men   = 1'b1;
        mwen  = wen_q;
        raddr = line_addr;
        waddr = line_addr;
        if (wen_q) begin
          wdata = wdata_q << {addr_q[2:0], 3'b000};
          wmask = size_mask(size_q, addr_q[2:0]);
        end
        state_next = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Response fields are only meaningful while the response is being offered.
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = resp_valid ? rdata_q : '0;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state   <= ST_IDLE;
      wen_q   <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      size_q  <= SZ_B;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && req_valid) begin
        wen_q   <= req_wen;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        size_q  <= req_size;
        err_q   <= misaligned_req;
        rdata_q <= '0;
      end
      if (state == ST_ACCESS && !wen_q) rdata_q <= load_data;
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a small byte-masked memory model at 0x80000000.
module tb_lsu_mem_ctrl;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;
  logic        men, mwen;
  logic [63:0] raddr, rdata, waddr, wdata;
  logic [7:0]  wmask;

  int checks = 0;
  int errors = 0;

  logic [63:0] mem [0:15];
  int          men_count = 0;
  logic        mon_mwen;
  logic [63:0] mon_waddr, mon_wdata;
  logic [7:0]  mon_wmask;

  lsu_mem_ctrl #(.XLEN(64), .ALIGN_CHECK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .men(men), .mwen(mwen), .raddr(raddr), .rdata(rdata),
    .waddr(waddr), .wdata(wdata), .wmask(wmask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rdata = mem[raddr[6:3]];

  // Memory model: counts access pulses and applies masked writes mid-cycle.
  always @(negedge clk) begin
    if (men) begin
      men_count++;
      mon_mwen  = mwen;
      mon_waddr = waddr;
      mon_wdata = wdata;
      mon_wmask = wmask;
      if (mwen)
        for (int b = 0; b < 8; b++)
          if (wmask[b]) mem[waddr[6:3]][8*b +: 8] = wdata[8*b +: 8];
    end
  end

  task automatic issue(input logic wen, input logic [63:0] addr, input logic [63:0] wd,
                       input logic [1:0] sz, input logic uns);
    @(negedge clk);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wd;
    req_size = sz; req_unsigned = uns; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Edges from accept to resp_valid; the accept edge itself counts as 1.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_resp;
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic load_expect(input string name, input logic [63:0] addr, input logic [1:0] sz,
                             input logic uns, input logic [63:0] exp);
    int lat;
    issue(1'b0, addr, 64'd0, sz, uns);
    wait_resp(lat);
    checks++;
    if (resp_rdata !== exp || resp_err !== 1'b0 || lat != 2) begin
      errors++;
      $display("FAIL %s got data=%h err=%b lat=%0d exp data=%h err=0 lat=2",
               name, resp_rdata, resp_err, lat, exp);
    end
    finish_resp();
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = 2'd0; req_unsigned = 1'b0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 64'd0) begin
      errors++;
      $display("FAIL reset_resp got ready=%b valid=%b err=%b rdata=%h exp 1 0 0 0",
               req_ready, resp_valid, resp_err, resp_rdata);
    end
    checks++;
    if (men !== 1'b0 || mwen !== 1'b0 || raddr !== 64'd0 || waddr !== 64'd0 ||
        wdata !== 64'd0 || wmask !== 8'd0) begin
      errors++;
      $display("FAIL reset_mem got men=%b mwen=%b raddr=%h wmask=%h exp all zero",
               men, mwen, raddr, wmask);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_load_double;
    int lat, base;
    base = men_count;
    issue(1'b0, 64'h8000_0008, 64'd0, 2'd3, 1'b0);
    checks++;
    if (men !== 1'b1 || mwen !== 1'b0 || raddr !== 64'h8000_0008 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL ld_access got men=%b mwen=%b raddr=%h ready=%b exp 1 0 0000000080000008 0",
               men, mwen, raddr, req_ready);
    end
    wait_resp(lat);
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL ld_latency got %0d exp 2", lat);
    end
    checks++;
    if (resp_rdata !== 64'h1122_3344_5566_7788 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL ld_data got %h err=%b exp 1122334455667788 err=0", resp_rdata, resp_err);
    end
    finish_resp();
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || men_count - base != 1) begin
      errors++;
      $display("FAIL ld_handshake got valid=%b ready=%b pulses=%0d exp 0 1 1",
               resp_valid, req_ready, men_count - base);
    end
  endtask

  task automatic test_sign_extend;
    load_expect("lb_signed",   64'h8000_0001, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FF80);
    load_expect("lbu",         64'h8000_0001, 2'd0, 1'b1, 64'h0000_0000_0000_0080);
    load_expect("lh_signed",   64'h8000_0000, 2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_80FF);
    load_expect("lw_signed",   64'h8000_0010, 2'd2, 1'b0, 64'hFFFF_FFFF_8000_0001);
    load_expect("lwu",         64'h8000_0010, 2'd2, 1'b1, 64'h0000_0000_8000_0001);
    load_expect("lw_upper",    64'h8000_0014, 2'd2, 1'b0, 64'h0000_0000_1234_5678);
  endtask

  task automatic test_store;
    int lat, base;
    base = men_count;
    issue(1'b1, 64'h8000_0006, 64'h0000_0000_0000_ABCD, 2'd1, 1'b0);
    wait_resp(lat);
    checks++;
    if (men_count - base != 1 || mon_mwen !== 1'b1 || mon_waddr !== 64'h8000_0000 ||
        mon_wmask !== 8'hC0 || mon_wdata !== 64'hABCD_0000_0000_0000) begin
      errors++;
      $display("FAIL sh_bus got pulses=%0d mwen=%b waddr=%h wmask=%h wdata=%h exp 1 1 0000000080000000 c0 abcd000000000000",
               men_count - base, mon_mwen, mon_waddr, mon_wmask, mon_wdata);
    end
    checks++;
    if (lat != 2 || resp_rdata !== 64'd0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL sh_resp got lat=%0d rdata=%h err=%b exp 2 0 0", lat, resp_rdata, resp_err);
    end
    finish_resp();
    load_expect("ld_after_sh", 64'h8000_0000, 2'd3, 1'b0, 64'hABCD_0000_0000_80FF);

    issue(1'b1, 64'h8000_0003, 64'h0000_0000_0000_005A, 2'd0, 1'b0);
    wait_resp(lat);
    checks++;
    if (mon_wmask !== 8'h08 || mon_wdata !== 64'h0000_0000_5A00_0000) begin
      errors++;
      $display("FAIL sb_bus got wmask=%h wdata=%h exp 08 000000005a000000", mon_wmask, mon_wdata);
    end
    finish_resp();
    load_expect("lwu_after_sb", 64'h8000_0000, 2'd2, 1'b1, 64'h0000_0000_5A00_80FF);
  endtask

  task automatic test_misaligned;
    int lat, base;
    base = men_count;
    issue(1'b0, 64'h8000_0002, 64'd0, 2'd2, 1'b0);
    wait_resp(lat);
    checks++;
    if (lat != 1 || resp_err !== 1'b1 || resp_rdata !== 64'd0) begin
      errors++;
      $display("FAIL lw_misaligned got lat=%0d err=%b rdata=%h exp 1 1 0", lat, resp_err, resp_rdata);
    end
    finish_resp();
    issue(1'b1, 64'h8000_0004, 64'hDEAD_BEEF_DEAD_BEEF, 2'd3, 1'b0);
    wait_resp(lat);
    checks++;
    if (lat != 1 || resp_err !== 1'b1) begin
      errors++;
      $display("FAIL sd_misaligned got lat=%0d err=%b exp 1 1", lat, resp_err);
    end
    finish_resp();
    checks++;
    if (men_count != base || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_nomem got pulses=%0d err_after=%b exp 0 0", men_count - base, resp_err);
    end
    load_expect("ld_after_bad_sd", 64'h8000_0000, 2'd3, 1'b0, 64'hABCD_0000_5A00_80FF);
  endtask

  task automatic test_backpressure;
    int lat, base;
    issue(1'b0, 64'h8000_0008, 64'd0, 2'd3, 1'b0);
    wait_resp(lat);
    base = men_count;
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 64'h8000_0008; req_wdata = 64'hFFFF; req_size = 2'd3;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 64'h1122_3344_5566_7788 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d got valid=%b rdata=%h ready=%b exp 1 1122334455667788 0",
                 i, resp_valid, resp_rdata, req_ready);
      end
    end
    checks++;
    if (men_count != base) begin
      errors++;
      $display("FAIL hold_nomen got pulses=%0d exp 0", men_count - base);
    end
    @(negedge clk); req_valid = 1'b0;
    finish_resp();
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release got valid=%b ready=%b exp 0 1", resp_valid, req_ready);
    end
  endtask

  task automatic test_reset_in_resp;
    int lat;
    issue(1'b0, 64'h8000_0010, 64'd0, 2'd3, 1'b0);
    wait_resp(lat);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 64'd0 || req_ready !== 1'b1 || men !== 1'b0) begin
      errors++;
      $display("FAIL rst_resp got valid=%b rdata=%h ready=%b men=%b exp 0 0 1 0",
               resp_valid, resp_rdata, req_ready, men);
    end
    @(negedge clk); rst_n = 1'b1;
    load_expect("ld_after_rst", 64'h8000_0008, 2'd3, 1'b0, 64'h1122_3344_5566_7788);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 64'd0;
    mem[0] = 64'h0000_0000_0000_80FF;
    mem[1] = 64'h1122_3344_5566_7788;
    mem[2] = 64'h1234_5678_8000_0001;
    test_reset();
    test_load_double();
    test_sign_extend();
    test_store();
    test_misaligned();
    test_backpressure();
    test_reset_in_resp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
